fft_peak_detect: RTL and testbench

// Streaming peak-bin detector on the FFT core output. Consumes one complex bin per valid beat,

---
 rtl/fft_peak_detect_pkg.sv | 21 ++
 rtl/fft_peak_detect_if.sv | 13 +
 rtl/fft_peak_detect_mag_sq.sv | 49 ++++
 rtl/fft_peak_detect.sv | 153 +++++++++++++++
 tb/tb_fft_peak_detect.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_peak_detect_pkg.sv
// rtl/fft_peak_detect_pkg.sv - shared types and helpers for the FFT peak-bin detector
package fft_peak_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_REPORT = 2'd2
  } fsm_state_t;

  function automatic int fft_bin_w(input int n_points);
    return $clog2(n_points);
  endfunction

  // LED position of a positive-half bin, clamped to the top LED.
  function automatic int led_index(input int bin, input int n_points, input int led_w);
    int idx;
    idx = (bin * led_w) / (n_points / 2);
    return (idx > led_w - 1) ? led_w - 1 : idx;
  endfunction

endpackage

// File: rtl/fft_peak_detect_if.sv
// rtl/fft_peak_detect_if.sv - FFT bin stream into the peak detector (no backpressure)
interface fft_peak_detect_if #(
  parameter int DATA_W = 16
);
  logic                     s_valid;
  logic                     s_sop;
  logic                     s_eop;
  logic signed [DATA_W-1:0] s_re;
  logic signed [DATA_W-1:0] s_im;

  modport master (output s_valid, s_sop, s_eop, s_re, s_im);
  modport slave  (input  s_valid, s_sop, s_eop, s_re, s_im);
endinterface

// File: rtl/fft_peak_detect_mag_sq.sv
// rtl/fft_peak_detect_mag_sq.sv - two-stage squared magnitude with valid/sop/eop sideband
module fft_mag_sq #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic                     in_eop,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic                     out_eop,
  output logic [2*DATA_W:0]        out_mag
);

  logic signed [2*DATA_W-1:0] re_ext, im_ext;
  logic        [2*DATA_W-1:0] re_sq, im_sq;
  logic                       v1, sop1, eop1;

  assign re_ext = {{DATA_W{in_re[DATA_W-1]}}, in_re};
  assign im_ext = {{DATA_W{in_im[DATA_W-1]}}, in_im};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      sop1      <= 1'b0;
      eop1      <= 1'b0;
      re_sq     <= '0;
      im_sq     <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_mag   <= '0;
    end else begin
      v1        <= in_valid;
      sop1      <= in_valid & in_sop;
      eop1      <= in_valid & in_eop;
      re_sq     <= re_ext * re_ext;
      im_sq     <= im_ext * im_ext;
      out_valid <= v1;
      out_sop   <= sop1;
      out_eop   <= eop1;
      out_mag   <= {1'b0, re_sq} + {1'b0, im_sq};
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - peak-bin tracker over the positive half-spectrum with
// threshold and multi-frame confirmation, driving LEDR as a one-hot frequency bar.
module fft_peak_detect
  import fft_peak_detect_pkg::*;
#(
  parameter int N_POINTS = 64,
  parameter int DATA_W   = 16,
  parameter int THRESH   = 1024,
  parameter int CONFIRM  = 2,
  parameter int LED_W    = 8,
  localparam int BIN_W   = fft_bin_w(N_POINTS),
  localparam int MAG_W   = 2*DATA_W+1
) (
  input  logic                 CLOCK_50,
  input  logic                 KEY,
  fft_peak_detect_if.slave     s,
  output logic                 peak_valid,
  output logic [BIN_W-1:0]     peak_bin,
  output logic [MAG_W-1:0]     peak_mag,
  output logic                 no_signal,
  output logic                 frame_err,
  output logic [LED_W-1:0]     LEDR
);

  localparam logic [BIN_W-1:0] LAST_BIN  = BIN_W'(N_POINTS - 1);
  localparam logic [BIN_W-1:0] HALF_BIN  = BIN_W'(N_POINTS / 2);
  localparam logic [MAG_W-1:0] THRESH_V  = MAG_W'(THRESH);
  localparam logic [3:0]       CONFIRM_V = 4'(CONFIRM);

  logic             d_valid, d_sop, d_eop;
  logic [MAG_W-1:0] d_mag;

  fft_mag_sq #(.DATA_W(DATA_W)) u_mag_sq (
    .clk      (CLOCK_50),
    .rst      (KEY),
    .in_valid (s.s_valid),
    .in_sop   (s.s_sop),
    .in_eop   (s.s_eop),
    .in_re    (s.s_re),
    .in_im    (s.s_im),
    .out_valid(d_valid),
    .out_sop  (d_sop),
    .out_eop  (d_eop),
    .out_mag  (d_mag)
  );

  fsm_state_t       state, next_state;
  logic [BIN_W-1:0] bin_cnt, max_bin, cand_bin;
  logic [MAG_W-1:0] max_mag;
  logic [3:0]       conf_cnt, conf_next;
  logic             start, advance, good_eop, bad_frame, no_sig_now;

  // Framing runs on the delayed stream so every decision sees the matching magnitude.
  always_comb begin
    next_state = state;
    start      = 1'b0;
    advance    = 1'b0;
    good_eop   = 1'b0;
    bad_frame  = 1'b0;
    case (state)
      ST_ACCUM: begin
        if (d_valid) begin
          if (d_sop) begin
            bad_frame = 1'b1;
            start     = 1'b1;
          end else if (d_eop) begin
            if (bin_cnt == LAST_BIN) begin
              good_eop   = 1'b1;
              next_state = ST_REPORT;
            end else begin
              bad_frame  = 1'b1;
              next_state = ST_IDLE;
            end
          end else if (bin_cnt == LAST_BIN) begin
            bad_frame  = 1'b1;
            next_state = ST_IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
        if (d_valid && d_sop) begin
          start      = 1'b1;
          next_state = ST_ACCUM;
        end
      end
    endcase
  end

  assign no_sig_now = (max_mag < THRESH_V);

  always_comb begin
    conf_next = 4'd1;
    if (conf_cnt != 4'd0 && max_bin == cand_bin)
      conf_next = (conf_cnt >= CONFIRM_V) ? CONFIRM_V : conf_cnt + 4'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      state      <= ST_IDLE;
      bin_cnt    <= '0;
      max_bin    <= '0;
      max_mag    <= '0;
      cand_bin   <= '0;
      conf_cnt   <= '0;
      peak_valid <= 1'b0;
      peak_bin   <= '0;
      peak_mag   <= '0;
      no_signal  <= 1'b0;
      frame_err  <= 1'b0;
      LEDR       <= '0;
    end else begin
      state      <= next_state;
      peak_valid <= 1'b0;
      if (bad_frame)
        frame_err <= 1'b1;
      if (start) begin
        bin_cnt <= BIN_W'(1);
        max_mag <= '0;
        max_bin <= '0;
      end else if (advance) begin
        bin_cnt <= bin_cnt + BIN_W'(1);
        // Strict compare keeps the lowest bin on ties.
        if (bin_cnt < HALF_BIN && d_mag > max_mag) begin
          max_mag <= d_mag;
          max_bin <= bin_cnt;
        end
      end
      if (good_eop) begin
        no_signal <= no_sig_now;
        if (no_sig_now) begin
          conf_cnt   <= '0;
          peak_bin   <= '0;
          peak_mag   <= '0;
          LEDR       <= '0;
          peak_valid <= 1'b1;
        end else begin
          conf_cnt <= conf_next;
          cand_bin <= max_bin;
          if (conf_next == CONFIRM_V) begin
            peak_bin   <= max_bin;
            peak_mag   <= max_mag;
            LEDR       <= LED_W'(1) << led_index(int'(max_bin), N_POINTS, LED_W);
            peak_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - randomized self-checking bench; CONFIRM=1 and CONFIRM=2
// instances share one stream and are checked against a frame-level reference model.
module tb_fft_peak_detect;
  localparam int N   = 64;
  localparam int DW  = 16;
  localparam int THR = 1024;
  localparam int LW  = 8;

  typedef struct {
    int     cyc;
    bit     pv;
    int     bin;
    longint mag;
    int     led;
    bit     nosig;
    bit     ferr;
  } rpt_t;

  logic clk = 1'b0;
  logic key;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        pv1, pv2, ns1, ns2, fe1, fe2;
  logic [5:0]  pbin1, pbin2;
  logic [32:0] pmag1, pmag2;
  logic [7:0]  led1, led2;

  fft_peak_detect_if #(.DATA_W(DW)) s_if ();

  fft_peak_detect #(.N_POINTS(N), .DATA_W(DW), .THRESH(THR), .CONFIRM(1), .LED_W(LW)) dut_c1 (
    .CLOCK_50(clk), .KEY(key), .s(s_if), .peak_valid(pv1), .peak_bin(pbin1),
    .peak_mag(pmag1), .no_signal(ns1), .frame_err(fe1), .LEDR(led1)
  );

  fft_peak_detect #(.N_POINTS(N), .DATA_W(DW), .THRESH(THR), .CONFIRM(2), .LED_W(LW)) dut_c2 (
    .CLOCK_50(clk), .KEY(key), .s(s_if), .peak_valid(pv2), .peak_bin(pbin2),
    .peak_mag(pmag2), .no_signal(ns2), .frame_err(fe2), .LEDR(led2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int     f_re [N];
  int     f_im [N];
  int     conf_v [2] = '{1, 2};
  int     m_cnt [2], m_cand [2], m_bin [2], m_led [2];
  longint m_mag [2];
  bit     m_nosig, m_err;
  rpt_t   exp_q0 [$], exp_q1 [$], act_q0 [$], act_q1 [$];

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic rpt_t snap(input int d);
    rpt_t r;
    r.cyc = cyc;
    if (d == 0) begin
      r.pv = pv1; r.bin = int'(pbin1); r.mag = longint'(pmag1); r.led = int'(led1);
      r.nosig = ns1; r.ferr = fe1;
    end else begin
      r.pv = pv2; r.bin = int'(pbin2); r.mag = longint'(pmag2); r.led = int'(led2);
      r.nosig = ns2; r.ferr = fe2;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (pv1) act_q0.push_back(snap(0));
    if (pv2) act_q1.push_back(snap(1));
  end

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = 0; m_cand[d] = 0; m_bin[d] = 0; m_led[d] = 0; m_mag[d] = 0;
    end
    m_nosig = 0;
    m_err   = 0;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Reference: strongest bin among 1..N/2-1 (first wins), then threshold and confirmation.
  task automatic model_frame(input int eop_cyc);
    longint best, mg;
    int     bb, li;
    bit     ns, fire;
    rpt_t   e;
    best = 0;
    bb   = 0;
    for (int b = 1; b < N/2; b++) begin
      mg = longint'(f_re[b]) * f_re[b] + longint'(f_im[b]) * f_im[b];
      if (mg > best) begin best = mg; bb = b; end
    end
    ns = (best < THR);
    m_nosig = ns;
    for (int d = 0; d < 2; d++) begin
      fire = 0;
      if (ns) begin
        m_cnt[d] = 0; m_bin[d] = 0; m_mag[d] = 0; m_led[d] = 0;
        fire = 1;
      end else begin
        if (m_cnt[d] > 0 && m_cand[d] == bb)
          m_cnt[d] = (m_cnt[d] + 1 > conf_v[d]) ? conf_v[d] : m_cnt[d] + 1;
        else begin
          m_cnt[d] = 1;
          m_cand[d] = bb;
        end
        if (m_cnt[d] == conf_v[d]) begin
          li = bb * LW / (N/2);
          if (li > LW - 1) li = LW - 1;
          m_bin[d] = bb; m_mag[d] = best; m_led[d] = 1 << li;
          fire = 1;
        end
      end
      if (fire) begin
        e.cyc = eop_cyc + 3; e.pv = 1; e.bin = m_bin[d]; e.mag = m_mag[d];
        e.led = m_led[d]; e.nosig = ns; e.ferr = m_err;
        if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      end
    end
  endtask

  task automatic check_pulses();
    rpt_t  e, a;
    string p;
    int    na, ne;
    for (int d = 0; d < 2; d++) begin
      p  = (d == 0) ? "c1" : "c2";
      na = (d == 0) ? act_q0.size() : act_q1.size();
      ne = (d == 0) ? exp_q0.size() : exp_q1.size();
      check_eq({p, "_pulse_count"}, na, ne);
      for (int i = 0; i < ((na < ne) ? na : ne); i++) begin
        if (d == 0) begin a = act_q0.pop_front(); e = exp_q0.pop_front(); end
        else begin a = act_q1.pop_front(); e = exp_q1.pop_front(); end
        check_eq({p, "_pulse_cycle"}, a.cyc, e.cyc);
        check_eq({p, "_pulse_bin"}, a.bin, e.bin);
        check_eq({p, "_pulse_mag"}, a.mag, e.mag);
        check_eq({p, "_pulse_led"}, a.led, e.led);
        check_eq({p, "_pulse_nosig"}, a.nosig, e.nosig);
        check_eq({p, "_pulse_ferr"}, a.ferr, e.ferr);
      end
      if (d == 0) begin act_q0.delete(); exp_q0.delete(); end
      else begin act_q1.delete(); exp_q1.delete(); end
    end
  endtask

  task automatic check_state(input string tag);
    rpt_t a;
    for (int d = 0; d < 2; d++) begin
      a = snap(d);
      check_eq({tag, (d == 0) ? "_c1_pv" : "_c2_pv"}, a.pv, 0);
      check_eq({tag, (d == 0) ? "_c1_bin" : "_c2_bin"}, a.bin, m_bin[d]);
      check_eq({tag, (d == 0) ? "_c1_mag" : "_c2_mag"}, a.mag, m_mag[d]);
      check_eq({tag, (d == 0) ? "_c1_led" : "_c2_led"}, a.led, m_led[d]);
      check_eq({tag, (d == 0) ? "_c1_nosig" : "_c2_nosig"}, a.nosig, m_nosig);
      check_eq({tag, (d == 0) ? "_c1_ferr" : "_c2_ferr"}, a.ferr, m_err);
    end
  endtask

  task automatic drive_beat(input int re, input int im, input bit sop, input bit eop);
    @(posedge clk); #1;
    s_if.s_valid = 1'b1; s_if.s_sop = sop; s_if.s_eop = eop;
    s_if.s_re = 16'(re); s_if.s_im = 16'(im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      s_if.s_valid = 1'b0; s_if.s_sop = 1'b0; s_if.s_eop = 1'b0;
    end
  endtask

  task automatic run_frame(input int len, input int eop_pos, output int eop_cyc);
    eop_cyc = -100;
    for (int b = 0; b < len; b++) begin
      drive_beat(f_re[b], f_im[b], b == 0, b == eop_pos);
      if (b == eop_pos) eop_cyc = cyc;
    end
  endtask

  task automatic fill_noise(input int amp);
    for (int b = 0; b < N; b++) begin
      f_re[b] = int'($urandom_range(0, 2*amp)) - amp;
      f_im[b] = int'($urandom_range(0, 2*amp)) - amp;
    end
  endtask

  task automatic fill_random();
    for (int b = 0; b < N; b++) begin
      f_re[b] = int'($urandom_range(0, 65535)) - 32768;
      f_im[b] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  task automatic tone_frame(input int bin, input int re, input int im);
    int ec;
    fill_noise(20);
    f_re[bin] = re; f_im[bin] = im;
    run_frame(N, N-1, ec);
    model_frame(ec);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ec, tb_bin;
    key = 1'b1;
    s_if.s_valid = 1'b0; s_if.s_sop = 1'b0; s_if.s_eop = 1'b0;
    s_if.s_re = '0; s_if.s_im = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1 key = 1'b0;
    check_state("reset");

    // Beats without sop in IDLE are ignored.
    for (int i = 0; i < 5; i++) drive_beat(3000, -3000, 1'b0, i == 2);
    idle(6);
    check_pulses();
    check_state("idle_junk");

    // Tone at 8, then 12, 12: CONFIRM=2 reports only on the third.
    tone_frame(8, 1000, 0);   idle(6); check_pulses(); check_state("tone8");
    tone_frame(12, 0, -1500); idle(6); check_pulses(); check_state("tone12a");
    tone_frame(12, 900, 900); idle(6); check_pulses(); check_state("tone12b");

    // Equal magnitudes at 5 and 9 with a larger mirror-half bin at 40.
    for (int r = 0; r < 2; r++) begin
      fill_noise(20);
      f_re[5] = 500; f_im[5] = 0; f_re[9] = 0; f_im[9] = 500;
      f_re[40] = 3000; f_im[40] = 0;
      run_frame(N, N-1, ec);
      model_frame(ec);
      idle(6);
      check_pulses();
      check_state("tie");
    end

    // Below threshold everywhere.
    for (int b = 0; b < N; b++) begin f_re[b] = 10; f_im[b] = 10; end
    run_frame(N, N-1, ec); model_frame(ec); idle(6); check_pulses(); check_state("nosig");

    // Random frames with random gaps, including back-to-back.
    tb_bin = 1;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 3) begin
        fill_random();
        run_frame(N, N-1, ec);
        model_frame(ec);
      end else begin
        if (i % 2 == 0) tb_bin = int'($urandom_range(1, 31));
        tone_frame(tb_bin, int'($urandom_range(0, 4000)) - 2000, 2500);
      end
      idle(int'($urandom_range(0, 2)));
    end
    idle(6); check_pulses(); check_state("random");

    // Explicit back-to-back pair.
    tone_frame(31, -32768, -32768);
    tone_frame(31, -32768, -32768);
    idle(6); check_pulses(); check_state("b2b");

    // Early eop at bin 30.
    fill_noise(20); f_re[3] = 4000;
    run_frame(31, 30, ec);
    m_err = 1;
    idle(6); check_pulses(); check_state("early_eop");

    // sop mid-frame restarts the frame.
    fill_noise(20);
    run_frame(10, -1, ec);
    tone_frame(17, 1200, -700);
    idle(6); check_pulses(); check_state("sop_restart");

    // Missing eop, then a clean frame.
    fill_noise(20);
    run_frame(N, -1, ec);
    idle(6); check_pulses(); check_state("no_eop");
    tone_frame(2, 700, 700); idle(6); check_pulses(); check_state("after_no_eop");

    // Reset asserted at bin 20 aborts the frame and clears everything.
    fill_noise(20); f_re[25] = 5000;
    run_frame(21, -1, ec);
    key = 1'b1;
    @(posedge clk); #1;
    key = 1'b0; s_if.s_valid = 1'b0; s_if.s_sop = 1'b0; s_if.s_eop = 1'b0;
    reset_model();
    idle(6); check_pulses(); check_state("mid_reset");
    tone_frame(25, 5000, 0); idle(6); check_pulses(); check_state("post_reset_a");
    tone_frame(25, 0, 5000); idle(6); check_pulses(); check_state("post_reset_b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
